// File: rtl/shared_pkg.sv
// Shared constants and types for the FIFO write arbiter slice.
package shared_pkg;

  localparam int unsigned FIFO_WIDTH    = 16;
  localparam int unsigned NUM_REQ_DEF   = 4;
  localparam int unsigned MAX_BURST_DEF = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_e;

  // Index width that stays legal for a single-port configuration.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-side handshake bundle for fifo_wr_arbiter.
interface fifo_wr_arbiter_if
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_overflow;

  // The arbiter is the write master towards the FIFO.
  modport master (
    input  req_valid, req_lock, req_data, fifo_full, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in
  );

  modport slave (
    output req_valid, req_lock, req_data, fifo_full, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in
  );

endinterface

// File: rtl/arb_rr_picker.sv
// Rotating first-one search: picks the first set request at or above rr_ptr, wrapping to 0.
module arb_rr_picker
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((32'(rr_ptr) + k) % NUM_REQ);
      if (!gnt_any && req[j]) begin
        gnt_any = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = j;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter into a single FIFO, with burst locking and per-port beat statistics.
module fifo_wr_arbiter
  import shared_pkg::*;
#(
  parameter int unsigned NUM_REQ   = NUM_REQ_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W    = idx_width(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  fifo_wr_arbiter_if.master        bus,
  input  logic                     clr_stats,
  output logic [NUM_REQ*CNT_W-1:0] acc_cnt,
  output logic                     err_overflow,
  output logic [IDX_W-1:0]         owner_id
);

  localparam int unsigned BEAT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] gnt;
  logic               xfer;
  logic               owner_valid;
  logic               owner_lock;
  logic               burst_end;

  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic             err_q;

  function automatic logic [IDX_W-1:0] wrap_inc(logic [IDX_W-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (bus.req_valid),
    .rr_ptr  (rr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_any (pick_any)
  );

  assign owner_valid = bus.req_valid[owner_q];
  assign owner_lock  = bus.req_lock[owner_q];
  assign burst_end   = !owner_lock || (beat_q == BEAT_W'(MAX_BURST - 1));

  // A full FIFO blocks every grant; in OWN only the locked owner can win.
  always_comb begin
    gnt  = '0;
    xfer = 1'b0;
    if (!bus.fifo_full) begin
      if (state_q == IDLE) begin
        gnt  = pick_gnt;
        xfer = pick_any;
      end else if (owner_valid) begin
        gnt[owner_q] = 1'b1;
        xfer         = 1'b1;
      end
    end
  end

  always_comb begin
    bus.fifo_data_in = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bus.fifo_data_in = bus.fifo_data_in | bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.fifo_wr_en = xfer;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    if (!bus.fifo_full) begin
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (bus.req_lock[pick_idx] && (MAX_BURST > 1)) begin
              state_d = OWN;
              owner_d = pick_idx;
              beat_d  = BEAT_W'(1);
            end else begin
              rr_d = wrap_inc(pick_idx);
            end
          end
        end
        OWN: begin
          // Owner releases on its last beat, on dropping lock, or when it goes fully quiet.
          if ((xfer && burst_end) || (!owner_valid && !owner_lock)) begin
            state_d = IDLE;
            rr_d    = wrap_inc(owner_q);
            beat_d  = '0;
          end else if (xfer) begin
            beat_d = beat_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      owner_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else if (clr_stats) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
      err_q <= err_q | bus.fifo_overflow;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_cnt_out
    assign acc_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign err_overflow = err_q;
  assign owner_id     = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter: arbitration order, locking, stalls, stats, reset.
module tb_fifo_wr_arbiter;
  import shared_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = FIFO_WIDTH;
  localparam int unsigned CW = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr_stats = 1'b0;
  logic [N*CW-1:0] acc_cnt;
  logic            err_overflow;
  logic [1:0]      owner_id;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(N)) bus ();

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .MAX_BURST (8),
    .CNT_W     (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clr_stats    (clr_stats),
    .acc_cnt      (acc_cnt),
    .err_overflow (err_overflow),
    .owner_id     (owner_id)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pdata(int p);
    return W'(16'hA000 + p * 16'h0111);
  endfunction

  task automatic init_inputs;
    bus.req_valid     = '0;
    bus.req_lock      = '0;
    bus.fifo_full     = 1'b0;
    bus.fifo_overflow = 1'b0;
    clr_stats         = 1'b0;
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = pdata(i);
  endtask

  task automatic do_reset;
    @(negedge clk);
    init_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    init_inputs();
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
    n_tests++; if (bus.fifo_wr_en !== 1'b0) begin n_fail++;
      $display("FAIL reset_wr_en: got %b want 0", bus.fifo_wr_en); end
    n_tests++; if (bus.fifo_data_in !== '0) begin n_fail++;
      $display("FAIL reset_data: got %h want 0", bus.fifo_data_in); end
    n_tests++; if (acc_cnt !== '0) begin n_fail++;
      $display("FAIL reset_acc_cnt: got %h want 0", acc_cnt); end
    n_tests++; if (err_overflow !== 1'b0) begin n_fail++;
      $display("FAIL reset_err: got %b want 0", err_overflow); end
    n_tests++; if (owner_id !== 2'd0) begin n_fail++;
      $display("FAIL reset_owner: got %0d want 0", owner_id); end
  endtask

  task automatic test_round_robin;
    int exp_p [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_r;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b1111;
      #1;
      exp_r = 4'b0001 << exp_p[k];
      n_tests++; if (bus.req_ready !== exp_r) begin n_fail++;
        $display("FAIL rr_ready k=%0d: got %b want %b", k, bus.req_ready, exp_r); end
      n_tests++; if (bus.fifo_wr_en !== 1'b1) begin n_fail++;
        $display("FAIL rr_wr_en k=%0d: got %b want 1", k, bus.fifo_wr_en); end
      n_tests++; if (bus.fifo_data_in !== pdata(exp_p[k])) begin n_fail++;
        $display("FAIL rr_data k=%0d: got %h want %h", k, bus.fifo_data_in, pdata(exp_p[k])); end
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    for (int p = 0; p < N; p++) begin
      n_tests++; if (acc_cnt[p*CW +: CW] !== ((p == 0) ? 16'd2 : 16'd1)) begin n_fail++;
        $display("FAIL rr_acc_cnt p=%0d: got %0d want %0d", p, acc_cnt[p*CW +: CW],
                 (p == 0) ? 2 : 1); end
    end
  endtask

  task automatic test_burst;
    int exp_p [10] = '{2, 2, 2, 2, 2, 2, 2, 2, 0, 2};
    logic [N-1:0] exp_r;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      bus.req_valid = (k == 0) ? 4'b0100 : 4'b0101;
      bus.req_lock  = 4'b0100;
      #1;
      exp_r = 4'b0001 << exp_p[k];
      n_tests++; if (bus.req_ready !== exp_r) begin n_fail++;
        $display("FAIL burst_ready k=%0d: got %b want %b", k, bus.req_ready, exp_r); end
      if (k >= 1 && k <= 7) begin
        n_tests++; if (owner_id !== 2'd2) begin n_fail++;
          $display("FAIL burst_owner k=%0d: got %0d want 2", k, owner_id); end
      end
    end
  endtask

  task automatic test_full_stall;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b0100;
      bus.req_lock  = 4'b0100;
      #1;
      n_tests++; if (bus.req_ready !== 4'b0100) begin n_fail++;
        $display("FAIL full_pre k=%0d: got %b want 0100", k, bus.req_ready); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b0110;
      bus.fifo_full = 1'b1;
      #1;
      n_tests++; if ({bus.req_ready, bus.fifo_wr_en} !== 5'b0) begin n_fail++;
        $display("FAIL full_block k=%0d: got ready=%b wr_en=%b want 0000/0", k,
                 bus.req_ready, bus.fifo_wr_en); end
      n_tests++; if (owner_id !== 2'd2) begin n_fail++;
        $display("FAIL full_owner k=%0d: got %0d want 2", k, owner_id); end
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.fifo_full = 1'b0;
      #1;
      n_tests++; if (bus.req_ready !== ((k < 4) ? 4'b0100 : 4'b0010)) begin n_fail++;
        $display("FAIL full_resume k=%0d: got %b want %b", k, bus.req_ready,
                 (k < 4) ? 4'b0100 : 4'b0010); end
    end
  endtask

  task automatic test_overflow;
    do_reset();
    @(negedge clk);
    bus.fifo_overflow = 1'b1;
    @(negedge clk);
    bus.fifo_overflow = 1'b0;
    #1;
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++;
      $display("FAIL ovf_set: got %b want 1", err_overflow); end
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (err_overflow !== 1'b1) begin n_fail++;
      $display("FAIL ovf_sticky: got %b want 1", err_overflow); end
    @(negedge clk);
    clr_stats         = 1'b1;
    bus.fifo_overflow = 1'b1;
    bus.req_valid     = 4'b0001;
    @(negedge clk);
    clr_stats         = 1'b0;
    bus.fifo_overflow = 1'b0;
    bus.req_valid     = '0;
    #1;
    n_tests++; if (err_overflow !== 1'b0) begin n_fail++;
      $display("FAIL ovf_clr_priority: got %b want 0", err_overflow); end
    n_tests++; if (acc_cnt[0 +: CW] !== 16'd0) begin n_fail++;
      $display("FAIL clr_drops_xfer: got %0d want 0", acc_cnt[0 +: CW]); end
  endtask

  task automatic test_saturate;
    do_reset();
    @(negedge clk);
    bus.req_valid = 4'b0010;
    repeat (65534) @(negedge clk);
    #1;
    n_tests++; if (acc_cnt[CW +: CW] !== 16'hFFFE) begin n_fail++;
      $display("FAIL sat_pre: got %h want fffe", acc_cnt[CW +: CW]); end
    repeat (6) @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_tests++; if (acc_cnt[CW +: CW] !== 16'hFFFF) begin n_fail++;
      $display("FAIL sat_hold: got %h want ffff", acc_cnt[CW +: CW]); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.req_valid = 4'b0100;
      bus.req_lock  = 4'b0100;
    end
    #1;
    n_tests++; if (owner_id !== 2'd2 || acc_cnt[2*CW +: CW] !== 16'd2) begin n_fail++;
      $display("FAIL mid_pre: got owner=%0d cnt=%0d want 2/2", owner_id, acc_cnt[2*CW +: CW]); end
    @(negedge clk);
    bus.req_valid = 4'b0101;
    rst_n         = 1'b0;
    #1;
    n_tests++; if (acc_cnt !== '0 || owner_id !== 2'd0) begin n_fail++;
      $display("FAIL mid_reset: got cnt=%h owner=%0d want 0/0", acc_cnt, owner_id); end
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL mid_reset_idle: got %b want 0001", bus.req_ready); end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.req_lock = '0;
    #1;
    n_tests++; if (bus.req_ready !== 4'b0001) begin n_fail++;
      $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_full_stall();
    test_overflow();
    test_saturate();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of producer ports.
REQ-002 Parameter MAX_BURST, default 8, maximum consecutive beats a locked owner may hold the FIFO.
REQ-003 Parameter CNT_W, default 16, width of each per-port accepted-beat counter.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  NUM_REQ  per-port write request.
REQ-007 req_lock  input  NUM_REQ  per-port burst-lock request, sampled with req_valid.
REQ-008 req_data  input  NUM_REQ*FIFO_WIDTH  per-port write data; port i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-009 req_ready  output  NUM_REQ  per-port accept; a beat transfers when req_valid[i] and req_ready[i] are both 1.
REQ-010 fifo_wr_en  output  1  FIFO write enable.
REQ-011 fifo_data_in  output  FIFO_WIDTH  FIFO write data.
REQ-012 fifo_full  input  1  FIFO full flag.
REQ-013 fifo_overflow  input  1  FIFO overflow flag.
REQ-014 clr_stats  input  1  synchronous clear of counters and error flag.
REQ-015 acc_cnt  output  NUM_REQ*CNT_W  per-port accepted-beat counters, port i at [i*CNT_W +: CNT_W].
REQ-016 err_overflow  output  1  sticky overflow error.
REQ-017 owner_id  output  $clog2(NUM_REQ)  current locked owner, valid only in state OWN.

Function
REQ-018 At most one req_ready bit is 1 per cycle; all req_ready are 0 while fifo_full=1.
REQ-019 fifo_wr_en is the OR of all transfers and fifo_data_in is the data of the granted port, both combinational in the same cycle (zero latency); fifo_data_in is 0 when fifo_wr_en=0.
REQ-020 The block has FSM states IDLE (no owner) and OWN (locked owner).
REQ-021 In IDLE, the grant goes to the first asserted req_valid searching upward from rr_ptr with wrap from NUM_REQ-1 to 0.
REQ-022 IDLE->OWN on a transfer from port i with req_lock[i]=1 and MAX_BURST>1: owner<=i, beat_cnt<=1.
REQ-023 In OWN, only the owner may be granted; each owner transfer increments beat_cnt.
REQ-024 OWN->IDLE when an owner transfer occurs with req_lock[owner]=0 or beat_cnt=MAX_BURST-1, or in any cycle where req_valid[owner]=0 and req_lock[owner]=0.
REQ-025 rr_ptr <= (granted port + 1) mod NUM_REQ on every IDLE transfer that does not enter OWN, and on every OWN->IDLE exit.
REQ-026 While fifo_full=1, state, owner, beat_cnt and rr_ptr hold.
REQ-027 Each transfer on port i increments acc_cnt[i], saturating at 2^CNT_W-1.
REQ-028 err_overflow is set on any cycle with fifo_overflow=1 and stays set until clr_stats.
REQ-029 clr_stats=1 zeroes all acc_cnt and err_overflow; a transfer in the same cycle is not counted, and clr_stats has priority over an overflow in the same cycle.

Reset
REQ-030 Asserting rst_n low immediately forces state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, all acc_cnt=0 and err_overflow=0, so req_ready=0 and fifo_wr_en=0 unless a request is valid.
REQ-031 An in-progress locked burst is abandoned on reset, and arbitration restarts from port 0 after release.

Structure
REQ-032 FIFO_WIDTH comes from shared_pkg; NUM_REQ/MAX_BURST defaults and the arb_state_e enum (IDLE, OWN) are added to shared_pkg.
REQ-033 The rotating first-one search is implemented in a combinational sub-module arb_rr_picker (inputs req vector and rr_ptr; outputs one-hot grant and index).

Verification
REQ-034 After reset, req_valid=4'b1111 with no lock and the FIFO never full -> grants in the order 0,1,2,3,0 on consecutive cycles, and fifo_data_in equals each port's data.
REQ-035 Port 2 asserts valid+lock for 12 beats with MAX_BURST=8 -> 8 back-to-back grants to port 2, then one grant to another valid port, then port 2 again.
REQ-036 fifo_full=1 for 3 cycles mid-burst with beat_cnt=4 -> req_ready=0 and fifo_wr_en=0 for those cycles; the burst resumes at beat 5 with the same owner.
REQ-037 Drive fifo_overflow=1 for one cycle -> err_overflow=1 until clr_stats; with clr_stats and fifo_overflow both 1 in the same cycle, err_overflow=0.
REQ-038 Port 1 performs 65540 single-beat transfers -> acc_cnt[1] saturates at 16'hFFFF.
REQ-039 Deassert rst_n during OWN at beat 3 -> state=IDLE and all counters=0 immediately; after release the first grant goes to the lowest valid port.
